run_scan_arbiter: RTL and testbench

RUN_SCAN_ARBITER -- requirements
Module: run_scan_arbiter

---
 rtl/run_scan_arbiter.sv | 171 +++++++++++++++++
 tb/tb_run_scan_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_scan_arbiter.sv
// run_scan_arbiter
//   Round-robin arbiter. It grants one requesting channel, latches that
//   channel's data word and scans it serially, MSB first. The scan looks for
//   the longest run of consecutive ones. One REPORT cycle presents the result,
//   then the arbiter returns to IDLE for one cycle before it can grant again.
//
// Ports
//   clock    in   rising-edge clock
//   reset    in   asynchronous, active-low reset
//   req      in   [N_CH]         per-channel scan request (level)
//   data     in   [N_CH*DATA_W]  channel i word at [i*DATA_W +: DATA_W]
//   gnt      out  [N_CH]         registered one-hot grant, zero in IDLE
//   busy     out                 high whenever not IDLE
//   done     out                 one-cycle strobe while in REPORT
//   done_id  out  [clog2(N_CH)]  channel index of the latest result
//   hit      out                 latest word held a run >= RUN_LEN
//   max_run  out  [clog2(DATA_W+1)] longest run of ones in latest word
module run_scan_arbiter #(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 8,
  parameter int RUN_LEN = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_CH-1:0]               req,
  input  logic [N_CH*DATA_W-1:0]        data,
  output logic [N_CH-1:0]               gnt,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(N_CH)-1:0]       done_id,
  output logic                          hit,
  output logic [$clog2(DATA_W+1)-1:0]   max_run
);

  localparam int ID_W = $clog2(N_CH);
  localparam int MR_W = $clog2(DATA_W + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  logic [1:0]        state_q,   state_d;
  logic [N_CH-1:0]   gnt_q,     gnt_d;
  logic [ID_W-1:0]   last_q,    last_d;
  logic [ID_W-1:0]   sel_q,     sel_d;
  logic [DATA_W-1:0] shreg_q,   shreg_d;
  logic [MR_W-1:0]   cnt_q,     cnt_d;
  logic [MR_W-1:0]   cur_q,     cur_d;
  logic [MR_W-1:0]   max_q,     max_d;
  logic [ID_W-1:0]   done_id_q, done_id_d;
  logic              hit_q,     hit_d;
  logic [MR_W-1:0]   max_run_q, max_run_d;

  logic [ID_W-1:0]   win_idx;
  logic              win_found;
  int                scan_idx;
  logic              cur_bit;
  logic [MR_W-1:0]   new_cur;
  logic [MR_W-1:0]   new_max;

  // Round-robin search. Start at last+1 and wrap, so the channel that was
  // served most recently has the lowest priority.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    scan_idx  = 0;
    for (int k = 1; k <= N_CH; k++) begin
      scan_idx = (int'(last_q) + k) % N_CH;
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(scan_idx);
      end
    end
  end

  // Run arithmetic for the bit consumed this cycle. The counters are wide
  // enough to hold DATA_W, so an all-ones word cannot wrap.
  always_comb begin
    cur_bit = shreg_q[DATA_W-1];
    new_cur = cur_bit ? (cur_q + MR_W'(1)) : '0;
    new_max = (new_cur > max_q) ? new_cur : max_q;
  end

  // Next-state logic. The result registers are written only on the last
  // shift, so they hold steady through REPORT and IDLE until the next result.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    sel_d     = sel_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    max_d     = max_q;
    done_id_d = done_id_q;
    hit_d     = hit_q;
    max_run_d = max_run_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_SHIFT;
          gnt_d   = N_CH'(1) << win_idx;
          sel_d   = win_idx;
          shreg_d = data[win_idx*DATA_W +: DATA_W];
          cnt_d   = '0;
          cur_d   = '0;
          max_d   = '0;
        end
      end
      ST_SHIFT: begin
        shreg_d = shreg_q << 1;
        cur_d   = new_cur;
        max_d   = new_max;
        cnt_d   = cnt_q + MR_W'(1);
        if (cnt_q == MR_W'(DATA_W - 1)) begin
          state_d   = ST_REPORT;
          done_id_d = sel_q;
          hit_d     = (int'(new_max) >= RUN_LEN);
          max_run_d = new_max;
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        last_d  = sel_q;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers. Reset abandons any scan in progress. Reset also points
  // last at the top channel, so channel 0 wins first after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      last_q    <= ID_W'(N_CH - 1);
      sel_q     <= '0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      cur_q     <= '0;
      max_q     <= '0;
      done_id_q <= '0;
      hit_q     <= 1'b0;
      max_run_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      max_q     <= max_d;
      done_id_q <= done_id_d;
      hit_q     <= hit_d;
      max_run_q <= max_run_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_REPORT);
  assign done_id = done_id_q;
  assign hit     = hit_q;
  assign max_run = max_run_q;

endmodule

// File: tb/tb_run_scan_arbiter.sv
// tb_run_scan_arbiter
//   Directed and randomized bench for run_scan_arbiter. A reference model
//   predicts the granted channel and the longest-run result for every scan.
//   The model uses a plain round-robin search and counts bits directly.
module tb_run_scan_arbiter;

  localparam int N_CH    = 4;
  localparam int DATA_W  = 8;
  localparam int RUN_LEN = 3;
  localparam int PERIOD  = 10;

  logic                        clock = 1'b0;
  logic                        reset;
  logic [N_CH-1:0]             req;
  logic [N_CH*DATA_W-1:0]      data;
  logic [N_CH-1:0]             gnt;
  logic                        busy;
  logic                        done;
  logic [$clog2(N_CH)-1:0]     done_id;
  logic                        hit;
  logic [$clog2(DATA_W+1)-1:0] max_run;

  int nVectors;
  int nMiscompares;
  int mLast;
  int mId;
  int mHit;
  int mMax;
  longint lastGrantT;

  run_scan_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W), .RUN_LEN(RUN_LEN)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .data    (data),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .hit     (hit),
    .max_run (max_run)
  );

  always #(PERIOD/2) clock = ~clock;

  // Longest run of ones, counted directly over the bits of the word.
  function automatic int longestRun(input logic [DATA_W-1:0] w);
    int cur;
    int best;
    cur  = 0;
    best = 0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (w[i]) cur++;
      else cur = 0;
      if (cur > best) best = cur;
    end
    return best;
  endfunction

  // First requester after the previously served channel, with wrap-around.
  function automatic int pickWinner(input logic [N_CH-1:0] r, input int last);
    for (int k = 1; k <= N_CH; k++) begin
      if (r[(last + k) % N_CH]) return (last + k) % N_CH;
    end
    return -1;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [N_CH-1:0] r, input logic [N_CH*DATA_W-1:0] d);
    req  = r;
    data = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    assert (obs === exp) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_gnt"},     32'(gnt),     32'd0);
    checkOutput({tag, "_busy"},    32'(busy),    32'd0);
    checkOutput({tag, "_done"},    32'(done),    32'd0);
    checkOutput({tag, "_done_id"}, 32'(done_id), 32'd0);
    checkOutput({tag, "_hit"},     32'(hit),     32'd0);
    checkOutput({tag, "_max_run"}, 32'(max_run), 32'd0);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_gnt"},     32'(gnt),     32'd0);
    checkOutput({tag, "_busy"},    32'(busy),    32'd0);
    checkOutput({tag, "_done"},    32'(done),    32'd0);
    checkOutput({tag, "_done_id"}, 32'(done_id), 32'(mId));
    checkOutput({tag, "_hit"},     32'(hit),     32'(mHit));
    checkOutput({tag, "_max_run"}, 32'(max_run), 32'(mMax));
  endtask

  // One complete scan. The DUT must be in IDLE and req must be nonzero, so
  // the next edge grants. The task can disturb req and data after the grant.
  task automatic runScan(input bit disturb, input logic [N_CH*DATA_W-1:0] newData,
                         input logic [N_CH-1:0] newReq, output int ch);
    int w;
    int mr;
    logic [DATA_W-1:0] word;
    w    = pickWinner(req, mLast);
    word = data[w*DATA_W +: DATA_W];
    mr   = longestRun(word);
    tick;
    lastGrantT = longint'($time);
    checkOutput("scan_gnt_e0",  32'(gnt),  32'(1) << w);
    checkOutput("scan_busy_e0", 32'(busy), 32'd1);
    checkOutput("scan_done_e0", 32'(done), 32'd0);
    if (disturb) applyStimulus(newReq, newData);
    repeat (DATA_W - 1) tick;
    checkOutput("scan_done_pre", 32'(done), 32'd0);
    checkOutput("scan_gnt_mid",  32'(gnt),  32'(1) << w);
    tick;
    mId  = w;
    mHit = (mr >= RUN_LEN) ? 1 : 0;
    mMax = mr;
    checkOutput("scan_done",    32'(done),    32'd1);
    checkOutput("scan_done_id", 32'(done_id), 32'(mId));
    checkOutput("scan_hit",     32'(hit),     32'(mHit));
    checkOutput("scan_max_run", 32'(max_run), 32'(mMax));
    checkOutput("scan_gnt_rep", 32'(gnt),     32'(1) << w);
    tick;
    checkIdle("scan_after");
    mLast = w;
    ch    = w;
  endtask

  initial begin
    int ch;
    longint prevT;
    logic [N_CH-1:0] r;
    nVectors     = 0;
    nMiscompares = 0;
    mLast = N_CH - 1;
    mId   = 0;
    mHit  = 0;
    mMax  = 0;
    lastGrantT = 0;
    reset = 1'b1;
    applyStimulus('0, '0);

    // Power-on reset, seen immediately and again after clock edges.
    #2 reset = 1'b0;
    #1 checkResetState("por");
    tick;
    tick;
    checkResetState("por_clk");
    reset = 1'b1;
    tick;
    checkIdle("idle_noreq");

    // Channel 0 with 0xE0 gives a run of exactly three.
    applyStimulus(4'b0001, 32'h0000_00E0);
    runScan(1'b0, '0, '0, ch);
    checkOutput("e0_id",  32'(ch),      32'd0);
    checkOutput("e0_max", 32'(max_run), 32'd3);
    checkOutput("e0_hit", 32'(hit),     32'd1);

    // Channel 2 alone with 0xB6, then the all-ones and all-zeros boundaries.
    applyStimulus(4'b0100, 32'h00B6_0000);
    runScan(1'b0, '0, '0, ch);
    checkOutput("b6_id",  32'(done_id), 32'd2);
    checkOutput("b6_max", 32'(max_run), 32'd2);
    checkOutput("b6_hit", 32'(hit),     32'd0);
    data = 32'h00FF_0000;
    runScan(1'b0, '0, '0, ch);
    checkOutput("ff_max", 32'(max_run), 32'd8);
    checkOutput("ff_hit", 32'(hit),     32'd1);
    data = 32'h0000_0000;
    runScan(1'b0, '0, '0, ch);
    checkOutput("00_max", 32'(max_run), 32'd0);
    checkOutput("00_hit", 32'(hit),     32'd0);

    // Results hold through idle cycles.
    applyStimulus('0, $urandom);
    repeat (3) begin
      tick;
      checkIdle("idle_hold");
    end

    // Data changes mid-scan must not affect the latched word.
    applyStimulus(4'b0001, 32'h0000_00E0);
    runScan(1'b1, 32'h0000_0000, 4'b0001, ch);
    checkOutput("latch_max", 32'(max_run), 32'd3);
    checkOutput("latch_hit", 32'(hit),     32'd1);

    // Dropping req mid-scan must not abort it.
    applyStimulus(4'b0001, $urandom);
    runScan(1'b1, $urandom, 4'b0000, ch);
    tick;
    checkIdle("drop_idle");

    // All four request from reset: served in order 0..3, back to back.
    reset = 1'b0;
    #1 checkResetState("async_rst");
    mLast = N_CH - 1;
    mId = 0;
    mHit = 0;
    mMax = 0;
    applyStimulus(4'b1111, $urandom);
    tick;
    reset = 1'b1;
    prevT = 0;
    for (int i = 0; i < N_CH; i++) begin
      runScan(1'b0, '0, '0, ch);
      checkOutput("all4_order", 32'(ch), 32'(i));
      if (i > 0) checkOutput("all4_gap", 32'(lastGrantT - prevT), 32'((DATA_W + 2) * PERIOD));
      prevT = lastGrantT;
      req[ch] = 1'b0;
    end

    // Channels 1 and 3 held high: they alternate.
    applyStimulus(4'b1010, $urandom);
    for (int i = 0; i < 4; i++) begin
      runScan(1'b0, '0, '0, ch);
      checkOutput("alt_order", 32'(ch), (i % 2 == 0) ? 32'd1 : 32'd3);
    end
    req = '0;
    tick;

    // Reset during the 4th SHIFT cycle of channel 2.
    applyStimulus(4'b0100, $urandom);
    tick;
    checkOutput("rst_gnt2", 32'(gnt), 32'h4);
    repeat (3) tick;
    reset = 1'b0;
    #1 checkResetState("rst_shift");
    tick;
    checkOutput("rst_nodone", 32'(done), 32'd0);
    tick;
    checkResetState("rst_hold");
    mLast = N_CH - 1;
    mId = 0;
    mHit = 0;
    mMax = 0;
    applyStimulus(4'b1111, $urandom);
    reset = 1'b1;
    runScan(1'b0, '0, '0, ch);
    checkOutput("rst_first", 32'(ch), 32'd0);
    req = '0;

    // Randomized traffic against the model.
    for (int n = 0; n < 12; n++) begin
      r = N_CH'($urandom_range(1, (1 << N_CH) - 1));
      applyStimulus(r, $urandom);
      runScan(1'($urandom_range(0, 1)), $urandom, N_CH'($urandom_range(0, (1 << N_CH) - 1)), ch);
      applyStimulus('0, data);
      repeat ($urandom_range(0, 2)) begin
        tick;
        checkIdle("rand_idle");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
